cpu_ctrl_fsm: RTL and testbench

//  Multi-cycle Moore controller that sequences the register-file/shifter/ALU datapath for one instruction per start.

---
 rtl/cpu_ctrl_pkg.sv | 82 ++++++++
 rtl/cpu_ctrl_fsm_dec.sv | 65 ++++++
 rtl/cpu_ctrl_fsm.sv | 148 ++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and types for the multi-cycle CPU controller.
// Optional feature macro: ALU_CMP_EN (enables the CMP instruction class).
package cpu_ctrl_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned NSEL_W  = 3;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned CLS_W   = 3;
  localparam int unsigned OPC_W   = 3;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned SHIFT_W = 2;

  // State encoding
  localparam logic [STATE_W-1:0] ST_WAIT   = 3'd0;
  localparam logic [STATE_W-1:0] ST_DECODE = 3'd1;
  localparam logic [STATE_W-1:0] ST_WR_IMM = 3'd2;
  localparam logic [STATE_W-1:0] ST_GET_A  = 3'd3;
  localparam logic [STATE_W-1:0] ST_GET_B  = 3'd4;
  localparam logic [STATE_W-1:0] ST_EXEC   = 3'd5;
  localparam logic [STATE_W-1:0] ST_WR_REG = 3'd6;

  typedef enum logic [STATE_W-1:0] {
    S_WAIT   = ST_WAIT,
    S_DECODE = ST_DECODE,
    S_WR_IMM = ST_WR_IMM,
    S_GET_A  = ST_GET_A,
    S_GET_B  = ST_GET_B,
    S_EXEC   = ST_EXEC,
    S_WR_REG = ST_WR_REG
  } state_t;

  // Opcode classes and op sub-codes
  localparam logic [OPC_W-1:0] OPC_MOV = 3'b110;
  localparam logic [OPC_W-1:0] OPC_ALU = 3'b101;

  localparam logic [OP_W-1:0] OP_MOV_REG = 2'b00;
  localparam logic [OP_W-1:0] OP_MOV_IMM = 2'b10;
  localparam logic [OP_W-1:0] OP_ADD     = 2'b00;
  localparam logic [OP_W-1:0] OP_CMP     = 2'b01;
  localparam logic [OP_W-1:0] OP_AND     = 2'b10;
  localparam logic [OP_W-1:0] OP_MVN     = 2'b11;

  // One-hot register-file selects
  localparam logic [NSEL_W-1:0] NSEL_NONE = 3'b000;
  localparam logic [NSEL_W-1:0] NSEL_RN   = 3'b001;
  localparam logic [NSEL_W-1:0] NSEL_RD   = 3'b010;
  localparam logic [NSEL_W-1:0] NSEL_RM   = 3'b100;

  // ALU operations
  localparam logic [ALUOP_W-1:0] ALU_ADD  = 2'b00;
  localparam logic [ALUOP_W-1:0] ALU_SUB  = 2'b01;
  localparam logic [ALUOP_W-1:0] ALU_AND  = 2'b10;
  localparam logic [ALUOP_W-1:0] ALU_NOTB = 2'b11;

  // Instruction classes produced by the decoder
  typedef enum logic [CLS_W-1:0] {
    C_MOV_IMM = 3'd0,
    C_MOV_REG = 3'd1,
    C_ALU_AB  = 3'd2,
    C_ALU_B   = 3'd3,
    C_CMP     = 3'd4,
    C_ILLEGAL = 3'd7
  } iclass_t;

  // Datapath control bundle driven each cycle
  typedef struct packed {
    logic                w;
    logic [NSEL_W-1:0]   nsel;
    logic                loada;
    logic                loadb;
    logic                loadc;
    logic                loads;
    logic                asel;
    logic                bsel;
    logic                vsel;
    logic                write;
    logic [ALUOP_W-1:0]  aluop;
    logic [SHIFT_W-1:0]  shift;
  } ctrl_t;

endpackage

// File: rtl/cpu_ctrl_fsm_dec.sv
// Combinational instruction decoder: IR -> class, ALU op, shift, flag update.
// Optional feature macro: ALU_CMP_EN (101_01 decodes as CMP instead of illegal).
module cpu_instr_dec
  import cpu_ctrl_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output logic [CLS_W-1:0]   cls_c,
  output logic [ALUOP_W-1:0] aluop_c,
  output logic [SHIFT_W-1:0] shift_c,
  output logic               loads_c
);

  logic [OPC_W-1:0] opcode;
  logic [OP_W-1:0]  op;

  assign opcode  = ir[15:13];
  assign op      = ir[12:11];
  assign shift_c = ir[4:3];

  // Register numbers are routed by the datapath, not by this controller
  logic unused_fields;
  assign unused_fields = ^{ir[10:5], ir[2:0]};

  // Map {opcode,op} to an instruction class and its ALU behaviour
  always_comb begin
    cls_c   = C_ILLEGAL;
    aluop_c = ALU_ADD;
    loads_c = 1'b0;
    case ({opcode, op})
      {OPC_MOV, OP_MOV_IMM}: begin
        cls_c = C_MOV_IMM;
      end
      {OPC_MOV, OP_MOV_REG}: begin
        cls_c   = C_MOV_REG;
        aluop_c = ALU_ADD;
      end
      {OPC_ALU, OP_ADD}: begin
        cls_c   = C_ALU_AB;
        aluop_c = ALU_ADD;
        loads_c = 1'b1;
      end
      {OPC_ALU, OP_AND}: begin
        cls_c   = C_ALU_AB;
        aluop_c = ALU_AND;
        loads_c = 1'b1;
      end
      {OPC_ALU, OP_MVN}: begin
        cls_c   = C_ALU_B;
        aluop_c = ALU_NOTB;
        loads_c = 1'b1;
      end
`ifdef ALU_CMP_EN
      {OPC_ALU, OP_CMP}: begin
        cls_c   = C_CMP;
        aluop_c = ALU_SUB;
        loads_c = 1'b1;
      end
`endif
      default: begin
        cls_c = C_ILLEGAL;
      end
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle Moore controller sequencing the regfile/shifter/ALU datapath.
// One instruction per accepted start; outputs are registered copies of the
// Moore decode of the state being entered.
// Optional feature macro: ALU_CMP_EN (adds the CMP flow, no writeback).
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                s,
  input  logic [INSTR_W-1:0]  instr,
  output logic                w,
  output logic                err,
  output logic [NSEL_W-1:0]   nsel,
  output logic                loada,
  output logic                loadb,
  output logic                loadc,
  output logic                loads,
  output logic                asel,
  output logic                bsel,
  output logic                vsel,
  output logic                write,
  output logic [ALUOP_W-1:0]  ALUop,
  output logic [SHIFT_W-1:0]  shift
);

  state_t               state, state_nxt;
  logic [INSTR_W-1:0]   ir, ir_nxt;
  logic                 err_q, err_nxt;
  ctrl_t                ctrl_q, ctrl_nxt;

  logic [CLS_W-1:0]     cls_c;
  logic [ALUOP_W-1:0]   aluop_c;
  logic [SHIFT_W-1:0]   shift_c;
  logic                 loads_c;
  iclass_t              cls;

  cpu_instr_dec u_dec (
    .ir      (ir),
    .cls_c   (cls_c),
    .aluop_c (aluop_c),
    .shift_c (shift_c),
    .loads_c (loads_c)
  );

  assign cls = iclass_t'(cls_c);

  // Next state, IR/err update, and Moore decode of the state being entered
  always_comb begin
    state_nxt = state;
    ir_nxt    = ir;
    err_nxt   = err_q;
    ctrl_nxt  = '0;

    case (state)
      S_WAIT: begin
        if (s) begin
          state_nxt = S_DECODE;
          ir_nxt    = instr;
          err_nxt   = 1'b0;
        end
      end
      S_DECODE: begin
        case (cls)
          C_MOV_IMM:          state_nxt = S_WR_IMM;
          C_MOV_REG, C_ALU_B: state_nxt = S_GET_B;
          C_ALU_AB, C_CMP:    state_nxt = S_GET_A;
          default: begin
            state_nxt = S_WAIT;
            err_nxt   = 1'b1;
          end
        endcase
      end
      S_WR_IMM: state_nxt = S_WAIT;
      S_GET_A:  state_nxt = S_GET_B;
      S_GET_B:  state_nxt = S_EXEC;
      S_EXEC:   state_nxt = (cls == C_CMP) ? S_WAIT : S_WR_REG;
      S_WR_REG: state_nxt = S_WAIT;
      default:  state_nxt = S_WAIT;
    endcase

    // IR only changes on the edge into DECODE, whose outputs ignore IR
    case (state_nxt)
      S_WAIT: begin
        ctrl_nxt.w = 1'b1;
      end
      S_WR_IMM: begin
        ctrl_nxt.nsel  = NSEL_RN;
        ctrl_nxt.vsel  = 1'b1;
        ctrl_nxt.write = 1'b1;
      end
      S_GET_A: begin
        ctrl_nxt.nsel  = NSEL_RN;
        ctrl_nxt.loada = 1'b1;
      end
      S_GET_B: begin
        ctrl_nxt.nsel  = NSEL_RM;
        ctrl_nxt.loadb = 1'b1;
      end
      S_EXEC: begin
        ctrl_nxt.loadc = 1'b1;
        ctrl_nxt.aluop = aluop_c;
        ctrl_nxt.shift = shift_c;
        ctrl_nxt.asel  = (cls == C_MOV_REG);
        ctrl_nxt.loads = loads_c;
      end
      S_WR_REG: begin
        ctrl_nxt.nsel  = NSEL_RD;
        ctrl_nxt.vsel  = 1'b0;
        ctrl_nxt.write = 1'b1;
      end
      default: begin
        ctrl_nxt = '0;
      end
    endcase
  end

  // State, IR, sticky error and output registers; reset abandons any writeback
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_WAIT;
      ir      <= '0;
      err_q   <= 1'b0;
      ctrl_q  <= '0;
      ctrl_q.w <= 1'b1;
    end else begin
      state   <= state_nxt;
      ir      <= ir_nxt;
      err_q   <= err_nxt;
      ctrl_q  <= ctrl_nxt;
    end
  end

  assign w     = ctrl_q.w;
  assign err   = err_q;
  assign nsel  = ctrl_q.nsel;
  assign loada = ctrl_q.loada;
  assign loadb = ctrl_q.loadb;
  assign loadc = ctrl_q.loadc;
  assign loads = ctrl_q.loads;
  assign asel  = ctrl_q.asel;
  assign bsel  = ctrl_q.bsel;
  assign vsel  = ctrl_q.vsel;
  assign write = ctrl_q.write;
  assign ALUop = ctrl_q.aluop;
  assign shift = ctrl_q.shift;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm. Honours ALU_CMP_EN when defined.
module tb_cpu_ctrl_fsm;

`ifdef ALU_CMP_EN
  localparam bit CMP_ON = 1'b1;
`else
  localparam bit CMP_ON = 1'b0;
`endif
  localparam int MAXC = 12;
  localparam int NV   = 10;
  localparam int NRND = 300;

  typedef struct packed {
    logic       w;
    logic       err;
    logic [2:0] nsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       vsel;
    logic       write;
    logic [1:0] aluop;
    logic [1:0] shift;
  } obs_t;

  typedef struct {
    logic [15:0] instr;
    int          lat;
    bit          err;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        s;
  logic [15:0] instr;
  logic        w, err, loada, loadb, loadc, loads, asel, bsel, vsel, write;
  logic [2:0]  nsel;
  logic [1:0]  ALUop, shift;

  int   passed = 0;
  int   total  = 0;
  bit   model_err = 1'b0;
  obs_t trace[$];
  vec_t vecs[NV];

  cpu_ctrl_fsm dut (
    .clk(clk), .reset(reset), .s(s), .instr(instr),
    .w(w), .err(err), .nsel(nsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .write(write),
    .ALUop(ALUop), .shift(shift)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t dut_obs();
    obs_t o;
    o = '0;
    o.w = w; o.err = err; o.nsel = nsel;
    o.loada = loada; o.loadb = loadb; o.loadc = loadc; o.loads = loads;
    o.asel = asel; o.bsel = bsel; o.vsel = vsel; o.write = write;
    o.aluop = ALUop; o.shift = shift;
    return o;
  endfunction

  function automatic obs_t idle_obs(input bit e);
    obs_t o;
    o = '0;
    o.w = 1'b1;
    o.err = e;
    return o;
  endfunction

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  // Reference: per-cycle datapath activity implied by the instruction's meaning
  task automatic build(input logic [15:0] ins);
    logic [2:0] opc;
    logic [1:0] op;
    bit mov_imm, mov_reg, alu, cmp, legal;
    obs_t e;
    opc     = ins[15:13];
    op      = ins[12:11];
    mov_imm = (opc == 3'b110) && (op == 2'b10);
    mov_reg = (opc == 3'b110) && (op == 2'b00);
    alu     = (opc == 3'b101);
    cmp     = alu && (op == 2'b01);
    legal   = mov_imm || mov_reg || (alu && (!cmp || CMP_ON));
    trace.delete();
    e = '0;
    trace.push_back(e);
    if (!legal) begin
      model_err = 1'b1;
      trace.push_back(idle_obs(1'b1));
      return;
    end
    model_err = 1'b0;
    if (mov_imm) begin
      e = '0; e.nsel = 3'b001; e.vsel = 1'b1; e.write = 1'b1;
      trace.push_back(e);
    end else begin
      if (alu && op != 2'b11) begin
        e = '0; e.nsel = 3'b001; e.loada = 1'b1;
        trace.push_back(e);
      end
      e = '0; e.nsel = 3'b100; e.loadb = 1'b1;
      trace.push_back(e);
      e = '0; e.loadc = 1'b1; e.shift = ins[4:3];
      e.aluop = mov_reg ? 2'b00 : op;
      e.asel  = mov_reg;
      e.loads = alu;
      trace.push_back(e);
      if (!cmp) begin
        e = '0; e.nsel = 3'b010; e.write = 1'b1;
        trace.push_back(e);
      end
    end
    trace.push_back(idle_obs(1'b0));
  endtask

  // Called at a negedge while idle; returns the observed cycles-to-ready
  task automatic issue(input logic [15:0] ins, input bit hold, output int lat);
    build(ins);
    s = 1'b1;
    instr = ins;
    lat = 0;
    for (int k = 1; k <= MAXC; k++) begin
      @(negedge clk);
      if (hold) instr = 16'($urandom);
      else s = 1'b0;
      if (k <= trace.size())
        check_obs($sformatf("i%04h_c%0d", ins, k), dut_obs(), trace[k-1]);
      if (w) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      total++;
      $display("FAIL i%04h_timeout: w=0 for %0d cycles, want w=1", ins, MAXC);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_obs("idle", dut_obs(), idle_obs(model_err));
    end
  endtask

  initial begin
    int lat;
    bit prev_hold;
    logic [15:0] r;
    bit hold;

    vecs[0] = '{16'hD205, 3, 1'b0};                    // MOV R2,#5
    vecs[1] = '{16'hC0A2, 5, 1'b0};                    // MOV reg
    vecs[2] = '{16'hB8C8, 5, 1'b0};                    // MVN
    vecs[3] = '{16'hA0A9, 6, 1'b0};                    // ADD R5,R0,R1 LSL1
    vecs[4] = '{16'hB29B, 6, 1'b0};                    // AND
    vecs[5] = '{16'hA901, CMP_ON ? 5 : 2, !CMP_ON};    // CMP R1,R1
    vecs[6] = '{16'hE000, 2, 1'b1};                    // opcode 111
    vecs[7] = '{16'hD7FF, 3, 1'b0};                    // legal clears err
    vecs[8] = '{16'hC800, 2, 1'b1};                    // 110_01
    vecs[9] = '{16'h0000, 2, 1'b1};                    // opcode 000

    reset = 1'b1;
    s = 1'b0;
    instr = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_obs("reset_state", dut_obs(), idle_obs(1'b0));
    reset = 1'b0;
    idle(2);

    // Reset while ADD is in EXEC: no writeback afterwards
    build(16'hA0A9);
    s = 1'b1;
    instr = 16'hA0A9;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      s = 1'b0;
      check_obs($sformatf("rst_seq_c%0d", k), dut_obs(), trace[k-1]);
    end
    reset = 1'b1;
    @(negedge clk);
    check_obs("rst_in_exec", dut_obs(), idle_obs(1'b0));
    reset = 1'b0;
    model_err = 1'b0;
    idle(3);

    // Table of single instructions
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].instr, 1'b0, lat);
      check_int($sformatf("lat_%04h", vecs[i].instr), lat, vecs[i].lat);
      check_int($sformatf("err_%04h", vecs[i].instr), int'(err), int'(vecs[i].err));
      idle(1);
    end

    // s held high with instr changing mid-flight; next accept only once ready
    issue(16'hA0A9, 1'b1, lat);
    check_int("hold_lat_add", lat, 6);
    issue(16'hD205, 1'b0, lat);
    check_int("hold_lat_movimm", lat, 3);

    // Error then legal instruction back-to-back
    issue(16'hE000, 1'b0, lat);
    check_int("err_set", int'(err), 1);
    issue(16'hC0A2, 1'b0, lat);
    check_int("err_clear", int'(err), 0);

    // Randomized instructions against the reference
    prev_hold = 1'b0;
    for (int i = 0; i < NRND; i++) begin
      r = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       r[15:13] = 3'b110;
        1, 2:    r[15:13] = 3'b101;
        default: ;
      endcase
      hold = ($urandom_range(0, 3) == 0);
      if (!prev_hold && $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      issue(r, hold, lat);
      prev_hold = hold;
    end
    s = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
